squarewave_analyzer: RTL

SQUAREWAVE_ANALYZER -- requirements
Module: squarewave_analyzer

---
 rtl/squarewave_analyzer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/squarewave_analyzer.sv
// Square-wave high/low/period analyzer with timeout detection.
// Ports: clk/reset (sync, active-high); w = asynchronous wave input;
//        high_cycles/low_cycles/period_cycles/m/n = results, valid = publish pulse, timeout = sticky stall flag.
module squarewave_analyzer #(
  parameter int CNT_W = 10,
  parameter int DIV   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w,
  output logic [CNT_W-1:0] high_cycles,
  output logic [CNT_W-1:0] low_cycles,
  output logic [CNT_W:0]   period_cycles,
  output logic [CNT_W-1:0] m,
  output logic [CNT_W-1:0] n,
  output logic             valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_V   = CNT_W'(DIV);

  typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;

  state_t           state;
  logic             w_meta;
  logic             w_s;
  logic             w_d;
  logic             rise;
  logic             fall;
  logic             sat;
  logic             have_high;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;

  assign rise = w_s & ~w_d;
  assign fall = ~w_s & w_d;
  // A phase that reaches the counter ceiling is a stall, even if the
  // edge ending it lands in this very cycle.
  assign sat  = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      w_meta        <= 1'b0;
      w_s           <= 1'b0;
      w_d           <= 1'b0;
      cnt           <= '0;
      have_high     <= 1'b0;
      high_len      <= '0;
      low_len       <= '0;
      state         <= IDLE;
      high_cycles   <= '0;
      low_cycles    <= '0;
      period_cycles <= '0;
      m             <= '0;
      n             <= '0;
      valid         <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      w_meta <= w;
      w_s    <= w_meta;
      w_d    <= w_s;

      // cnt equals the number of cycles w_s has held its current level.
      if (rise || fall) begin
        cnt <= CNT_ONE;
      end else if (!sat) begin
        cnt <= cnt + CNT_ONE;
      end

      valid <= 1'b0;

      if (sat) begin
        timeout   <= 1'b1;
        have_high <= 1'b0;
        state     <= IDLE;
      end else begin
        case (state)
          // Partial phase after reset/timeout is unusable; resync on a fall.
          IDLE: begin
            if (fall) begin
              have_high <= 1'b0;
              state     <= MEAS_LOW;
            end
          end
          MEAS_LOW: begin
            if (rise) begin
              low_len <= cnt;
              state   <= MEAS_HIGH;
              // Publish only once a complete high phase precedes this low.
              if (have_high) begin
                high_cycles   <= high_len;
                low_cycles    <= cnt;
                period_cycles <= {1'b0, high_len} + {1'b0, cnt};
                m             <= high_len / DIV_V;
                n             <= cnt / DIV_V;
                valid         <= 1'b1;
                timeout       <= 1'b0;
              end
            end
          end
          MEAS_HIGH: begin
            if (fall) begin
              high_len  <= cnt;
              have_high <= 1'b1;
              state     <= MEAS_LOW;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // low_len holds the most recent low phase, published or not; it is kept
  // for observation and deliberately has no other consumer.
  logic unused_low_len;
  assign unused_low_len = ^low_len;

endmodule
